bp_me_nonsynth_lce_req_tracker: RTL and testbench

Non-synthesizable LCE transaction checker. It taps the same handshakes as the per-LCE trace monitor on the LCE-CCE interface and tracks every accepted LCE request until its completing command. It reports outstanding count, latency statistics and protocol errors (table overflow, unmatched completion, timeout) to the testbench. There is one instance per LCE, bound beside the trace monitor in the ME test harness.

---
 rtl/bp_me_nonsynth_lce_req_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_bp_me_nonsynth_lce_req_tracker.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_nonsynth_lce_req_tracker.sv
// Per-LCE request tracker: follows each accepted LCE request until its completing command.
// Optional BP_ME_LCE_TRACKER_LOG_EN adds a per-LCE text log of allocations, completions and errors.
module bp_me_nonsynth_lce_req_tracker #(
  parameter int paddr_width_p     = 40,
  parameter int lce_id_width_p    = 4,
  parameter int block_width_p     = 512,
  parameter int max_outstanding_p = 4,
  parameter int timeout_cycles_p  = 10000,
  localparam int msg_type_width_lp    = 4,
  localparam int lce_cce_req_width_lp = msg_type_width_lp + paddr_width_p,
  localparam int lce_cmd_width_lp     = msg_type_width_lp + lce_id_width_p + paddr_width_p,
  localparam int out_width_lp         = $clog2(max_outstanding_p + 1)
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [lce_id_width_p-1:0]       lce_id_i,
  input  logic [lce_cce_req_width_lp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  input  logic                            lce_req_ready_i,
  input  logic [lce_cmd_width_lp-1:0]     lce_cmd_i,
  input  logic                            lce_cmd_v_i,
  input  logic                            lce_cmd_yumi_i,
  output logic [out_width_lp-1:0]         outstanding_o,
  output logic [31:0]                     completed_o,
  output logic [31:0]                     max_latency_o,
  output logic                            error_o,
  output logic [1:0]                      error_code_o
);

  localparam int idx_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
  localparam int off_lp   = $clog2(block_width_p / 8);

  localparam logic [3:0] e_lce_cmd_set_tag_wakeup = 4'd5;
  localparam logic [3:0] e_lce_cmd_uc_st_done     = 4'd7;
  localparam logic [3:0] e_lce_cmd_data           = 4'd8;
  localparam logic [3:0] e_lce_cmd_uc_data        = 4'd9;

  // Message layouts: request {msg_type, addr}; command {msg_type, dst_id, addr}
  logic [paddr_width_p-1:0]  req_blk, cmd_blk;
  logic [3:0]                req_type, cmd_type;
  logic [lce_id_width_p-1:0] cmd_dst;
  logic                      req_fire, cmd_fire, is_completion;

  assign req_type = lce_req_i[lce_cce_req_width_lp-1 -: msg_type_width_lp];
  assign req_blk  = {lce_req_i[paddr_width_p-1:off_lp], {off_lp{1'b0}}};
  assign cmd_type = lce_cmd_i[lce_cmd_width_lp-1 -: msg_type_width_lp];
  assign cmd_dst  = lce_cmd_i[paddr_width_p +: lce_id_width_p];
  assign cmd_blk  = {lce_cmd_i[paddr_width_p-1:off_lp], {off_lp{1'b0}}};
  assign req_fire = lce_req_v_i & lce_req_ready_i;
  assign cmd_fire = lce_cmd_v_i & lce_cmd_yumi_i;
  assign is_completion = cmd_fire && (cmd_dst == lce_id_i) &&
                         ((cmd_type == e_lce_cmd_data) || (cmd_type == e_lce_cmd_uc_data) ||
                          (cmd_type == e_lce_cmd_uc_st_done) || (cmd_type == e_lce_cmd_set_tag_wakeup));

  logic [max_outstanding_p-1:0]                    valid_q, valid_d, to_q, to_d;
  logic [max_outstanding_p-1:0][paddr_width_p-1:0] addr_q, addr_d;
  logic [max_outstanding_p-1:0][3:0]               type_q, type_d;
  logic [max_outstanding_p-1:0][31:0]              age_q, age_d;
  logic [out_width_lp-1:0]                         outstanding_q, outstanding_d;
  logic [31:0]                                     completed_q, completed_d, max_lat_q, max_lat_d;
  logic                                            error_q, error_d;
  logic [1:0]                                      code_q, code_d;

  logic                free_found, match_found, timeout_hit, overflow, unmatched, alloc, retire;
  logic [idx_w_lp-1:0] free_idx, match_idx;
  logic [31:0]         best_age, latency;

  always_comb begin
    valid_d       = valid_q;
    to_d          = to_q;
    addr_d        = addr_q;
    type_d        = type_q;
    age_d         = age_q;
    outstanding_d = outstanding_q;
    completed_d   = completed_q;
    max_lat_d     = max_lat_q;
    error_d       = error_q;
    code_d        = code_q;
    free_found    = 1'b0;
    free_idx      = '0;
    match_found   = 1'b0;
    match_idx     = '0;
    best_age      = '0;
    timeout_hit   = 1'b0;
    latency       = '0;

    // Allocation and matching both look only at entries valid before this edge
    for (int i = 0; i < max_outstanding_p; i++) begin
      if (!valid_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = idx_w_lp'(i);
      end
      if (valid_q[i] && (addr_q[i] == cmd_blk) && (!match_found || (age_q[i] > best_age))) begin
        match_found = 1'b1;
        match_idx   = idx_w_lp'(i);
        best_age    = age_q[i];
      end
      if (valid_q[i]) begin
        if (age_q[i] != 32'hFFFF_FFFF) age_d[i] = age_q[i] + 32'd1;
        if ((age_q[i] == 32'(timeout_cycles_p - 1)) && !to_q[i]) begin
          to_d[i]     = 1'b1;
          timeout_hit = 1'b1;
        end
      end
    end

    overflow  = req_fire && !free_found;
    unmatched = is_completion && !match_found;
    retire    = is_completion && match_found;
    alloc     = req_fire && free_found;

    if (retire) begin
      valid_d[match_idx] = 1'b0;
      to_d[match_idx]    = 1'b0;
      latency = (best_age == 32'hFFFF_FFFF) ? best_age : best_age + 32'd1;
      if (completed_q != 32'hFFFF_FFFF) completed_d = completed_q + 32'd1;
      if (latency > max_lat_q) max_lat_d = latency;
    end

    if (alloc) begin
      valid_d[free_idx] = 1'b1;
      to_d[free_idx]    = 1'b0;
      addr_d[free_idx]  = req_blk;
      type_d[free_idx]  = req_type;
      age_d[free_idx]   = '0;
    end

    outstanding_d = outstanding_q + out_width_lp'(alloc) - out_width_lp'(retire);

    if (!error_q) begin
      if (overflow) begin
        error_d = 1'b1;
        code_d  = 2'd1;
      end else if (unmatched) begin
        error_d = 1'b1;
        code_d  = 2'd2;
      end else if (timeout_hit) begin
        error_d = 1'b1;
        code_d  = 2'd3;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q       <= '0;
      to_q          <= '0;
      addr_q        <= '0;
      type_q        <= '0;
      age_q         <= '0;
      outstanding_q <= '0;
      completed_q   <= '0;
      max_lat_q     <= '0;
      error_q       <= 1'b0;
      code_q        <= 2'd0;
    end else begin
      valid_q       <= valid_d;
      to_q          <= to_d;
      addr_q        <= addr_d;
      type_q        <= type_d;
      age_q         <= age_d;
      outstanding_q <= outstanding_d;
      completed_q   <= completed_d;
      max_lat_q     <= max_lat_d;
      error_q       <= error_d;
      code_q        <= code_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign completed_o   = completed_q;
  assign max_latency_o = max_lat_q;
  assign error_o       = error_q;
  assign error_code_o  = code_q;

  logic unused_offsets;
  assign unused_offsets = ^{lce_req_i[off_lp-1:0], lce_cmd_i[off_lp-1:0]};

`ifdef BP_ME_LCE_TRACKER_LOG_EN
  // Log lines are tagged with the tracked LCE id and emitted only out of reset
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (alloc)
        $display("lce_track_%0x %0t alloc addr=%0x type=%0d entry=%0d",
                 lce_id_i, $time, req_blk, req_type, free_idx);
      if (retire)
        $display("lce_track_%0x %0t complete addr=%0x type=%0d entry=%0d latency=%0d",
                 lce_id_i, $time, cmd_blk, type_q[match_idx], match_idx, latency);
      if (overflow)
        $display("lce_track_%0x %0t error overflow addr=%0x entry=none", lce_id_i, $time, req_blk);
      if (unmatched)
        $display("lce_track_%0x %0t error unmatched addr=%0x entry=none", lce_id_i, $time, cmd_blk);
      for (int i = 0; i < max_outstanding_p; i++)
        if (valid_q[i] && !to_q[i] && (age_q[i] == 32'(timeout_cycles_p - 1)))
          $display("lce_track_%0x %0t error timeout addr=%0x entry=%0d", lce_id_i, $time, addr_q[i], i);
    end
  end
`else
  logic unused_types;
  assign unused_types = ^type_q;
`endif

endmodule

// File: tb/tb_bp_me_nonsynth_lce_req_tracker.sv
// Self-checking bench for bp_me_nonsynth_lce_req_tracker: timestamp-based reference model
// compared every cycle, plus hand-computed checks for each directed scenario.
module tb_bp_me_nonsynth_lce_req_tracker;

  localparam int MAX = 4;
  localparam int TO  = 20;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [3:0]  lce_id_i = 4'd3;
  logic [43:0] lce_req_i = '0;
  logic        lce_req_v_i = 1'b0;
  logic        lce_req_ready_i = 1'b0;
  logic [47:0] lce_cmd_i = '0;
  logic        lce_cmd_v_i = 1'b0;
  logic        lce_cmd_yumi_i = 1'b0;
  logic [2:0]  outstanding_o;
  logic [31:0] completed_o;
  logic [31:0] max_latency_o;
  logic        error_o;
  logic [1:0]  error_code_o;

  localparam logic [3:0] SET_TAG = 4'd4, WAKEUP = 4'd5, ST_DONE = 4'd7, DATA = 4'd8, UC_DATA = 4'd9;

  always #5 clk_i = ~clk_i;

  bp_me_nonsynth_lce_req_tracker #(
    .paddr_width_p(40), .lce_id_width_p(4), .block_width_p(512),
    .max_outstanding_p(MAX), .timeout_cycles_p(TO)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .lce_id_i(lce_id_i),
    .lce_req_i(lce_req_i), .lce_req_v_i(lce_req_v_i), .lce_req_ready_i(lce_req_ready_i),
    .lce_cmd_i(lce_cmd_i), .lce_cmd_v_i(lce_cmd_v_i), .lce_cmd_yumi_i(lce_cmd_yumi_i),
    .outstanding_o(outstanding_o), .completed_o(completed_o), .max_latency_o(max_latency_o),
    .error_o(error_o), .error_code_o(error_code_o)
  );

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: each entry remembers the edge number it was accepted on
  bit          mValid[MAX];
  logic [39:0] mAddr[MAX];
  longint      mStart[MAX];
  bit          mTo[MAX];
  longint      cyc;
  logic [31:0] mCompleted, mMaxLat, mOut;
  logic        mErr;
  logic [1:0]  mCode;

  function automatic logic [39:0] blk(input logic [39:0] a);
    return {a[39:6], 6'b0};
  endfunction

  always @(posedge clk_i or negedge reset_n_i) begin : model
    bit reqFire, cmpFire, ovf, unm, tmo;
    int freeIdx, matchIdx;
    longint lat;
    logic [3:0] ct;
    if (!reset_n_i) begin
      for (int i = 0; i < MAX; i++) begin
        mValid[i] = 1'b0; mTo[i] = 1'b0; mAddr[i] = '0; mStart[i] = 0;
      end
      cyc = 0; mCompleted = '0; mMaxLat = '0; mOut = '0; mErr = 1'b0; mCode = 2'd0;
    end else begin
      cyc++;
      ct = lce_cmd_i[47:44];
      reqFire = lce_req_v_i && lce_req_ready_i;
      cmpFire = lce_cmd_v_i && lce_cmd_yumi_i && (lce_cmd_i[43:40] == lce_id_i) &&
                (ct == WAKEUP || ct == ST_DONE || ct == DATA || ct == UC_DATA);
      freeIdx = -1;
      matchIdx = -1;
      tmo = 1'b0;
      for (int i = 0; i < MAX; i++) begin
        if (!mValid[i] && freeIdx < 0) freeIdx = i;
        if (mValid[i] && mAddr[i] == blk(lce_cmd_i[39:0]) &&
            (matchIdx < 0 || mStart[i] < mStart[matchIdx])) matchIdx = i;
        if (mValid[i] && !mTo[i] && (cyc - mStart[i] == TO)) begin
          mTo[i] = 1'b1;
          tmo = 1'b1;
        end
      end
      ovf = reqFire && freeIdx < 0;
      unm = cmpFire && matchIdx < 0;
      if (cmpFire && matchIdx >= 0) begin
        mValid[matchIdx] = 1'b0;
        lat = cyc - mStart[matchIdx];
        if (mCompleted != 32'hFFFF_FFFF) mCompleted = mCompleted + 1;
        if (lat > longint'(mMaxLat)) mMaxLat = 32'(lat);
      end
      if (reqFire && freeIdx >= 0) begin
        mValid[freeIdx] = 1'b1;
        mAddr[freeIdx]  = blk(lce_req_i[39:0]);
        mStart[freeIdx] = cyc;
        mTo[freeIdx]    = 1'b0;
      end
      mOut = '0;
      for (int i = 0; i < MAX; i++) if (mValid[i]) mOut = mOut + 1;
      if (!mErr && (ovf || unm || tmo)) begin
        mErr  = 1'b1;
        mCode = ovf ? 2'd1 : (unm ? 2'd2 : 2'd3);
      end
    end
  end

  // Every cycle out of reset, the registered outputs must equal the model
  always @(negedge clk_i) begin
    if (reset_n_i) begin
      testsRun += 5;
      if (32'(outstanding_o) !== mOut) begin
        testsFailed++;
        $display("[TB] FAIL model_outstanding t=%0t got %0d want %0d", $time, outstanding_o, mOut);
      end
      if (completed_o !== mCompleted) begin
        testsFailed++;
        $display("[TB] FAIL model_completed t=%0t got %0d want %0d", $time, completed_o, mCompleted);
      end
      if (max_latency_o !== mMaxLat) begin
        testsFailed++;
        $display("[TB] FAIL model_max_latency t=%0t got %0d want %0d", $time, max_latency_o, mMaxLat);
      end
      if (error_o !== mErr) begin
        testsFailed++;
        $display("[TB] FAIL model_error t=%0t got %0d want %0d", $time, error_o, mErr);
      end
      if (error_code_o !== mCode) begin
        testsFailed++;
        $display("[TB] FAIL model_error_code t=%0t got %0d want %0d", $time, error_code_o, mCode);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
    end
  endtask

  // Drives one edge's worth of inputs, returns just after that edge with handshakes dropped
  task automatic applyStimulus(input bit rv, input bit rr, input logic [39:0] ra,
                               input bit cv, input bit cy, input logic [3:0] ct,
                               input logic [3:0] cd, input logic [39:0] ca);
    lce_req_i       = {4'h1, ra};
    lce_req_v_i     = rv;
    lce_req_ready_i = rr;
    lce_cmd_i       = {ct, cd, ca};
    lce_cmd_v_i     = cv;
    lce_cmd_yumi_i  = cy;
    @(posedge clk_i);
    #2;
    lce_req_v_i     = 1'b0;
    lce_req_ready_i = 1'b0;
    lce_cmd_v_i     = 1'b0;
    lce_cmd_yumi_i  = 1'b0;
  endtask

  task automatic req(input logic [39:0] a);
    applyStimulus(1, 1, a, 0, 0, DATA, 4'd3, 40'h0);
  endtask

  task automatic cmd(input logic [3:0] t, input logic [39:0] a);
    applyStimulus(0, 0, 40'h0, 1, 1, t, 4'd3, a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic doReset();
    reset_n_i = 1'b0;
    #1;
    checkOutput("reset_outstanding", 32'(outstanding_o), 0);
    checkOutput("reset_completed", completed_o, 0);
    checkOutput("reset_max_latency", max_latency_o, 0);
    checkOutput("reset_error", 32'(error_o), 0);
    checkOutput("reset_code", 32'(error_code_o), 0);
    @(posedge clk_i);
    #2;
    reset_n_i = 1'b1;
  endtask

  initial begin
    $display("[TB] start");
    #3;
    doReset();

    // Single request, ignored commands in between, offset bits differ on completion
    req(40'h80_0000_0040);
    checkOutput("s1_outstanding_after_req", 32'(outstanding_o), 1);
    cmd(SET_TAG, 40'h80_0000_0040);
    applyStimulus(0, 0, 40'h0, 1, 1, DATA, 4'd5, 40'h80_0000_0040);
    applyStimulus(0, 0, 40'h0, 1, 0, DATA, 4'd3, 40'h80_0000_0040);
    applyStimulus(1, 0, 40'h80_0000_0080, 0, 0, DATA, 4'd3, 40'h0);
    checkOutput("s1_outstanding_mid", 32'(outstanding_o), 1);
    cmd(DATA, 40'h80_0000_0047);
    checkOutput("s1_outstanding_done", 32'(outstanding_o), 0);
    checkOutput("s1_completed", completed_o, 1);
    checkOutput("s1_max_latency", max_latency_o, 5);
    checkOutput("s1_error", 32'(error_o), 0);

    // Overflow on the fifth request
    doReset();
    for (int i = 0; i < 4; i++) req(40'h1000 + 40'(i * 64));
    checkOutput("s2_no_error_when_full", 32'(error_o), 0);
    req(40'h2000);
    checkOutput("s2_outstanding", 32'(outstanding_o), 4);
    checkOutput("s2_error", 32'(error_o), 1);
    checkOutput("s2_code", 32'(error_code_o), 1);

    // Completion with an empty table
    doReset();
    cmd(ST_DONE, 40'h100);
    checkOutput("s3_code", 32'(error_code_o), 2);
    checkOutput("s3_completed", completed_o, 0);

    // Duplicate addresses retire oldest first
    doReset();
    req(40'h200);
    idle(2);
    req(40'h200);
    idle(6);
    cmd(UC_DATA, 40'h200);
    checkOutput("s4_latency_first", max_latency_o, 10);
    checkOutput("s4_outstanding_mid", 32'(outstanding_o), 1);
    cmd(WAKEUP, 40'h200);
    checkOutput("s4_max_latency", max_latency_o, 10);
    checkOutput("s4_completed", completed_o, 2);
    checkOutput("s4_error", 32'(error_o), 0);

    // Timeout fires on edge 20 and the entry still retires later
    doReset();
    req(40'h400);
    idle(19);
    checkOutput("s5_no_timeout_yet", 32'(error_code_o), 0);
    idle(1);
    checkOutput("s5_timeout_code", 32'(error_code_o), 3);
    checkOutput("s5_outstanding", 32'(outstanding_o), 1);
    idle(4);
    cmd(DATA, 40'h400);
    checkOutput("s5_late_latency", max_latency_o, 25);
    checkOutput("s5_late_completed", completed_o, 1);

    // Same-cycle request and completion never self-match
    doReset();
    applyStimulus(1, 1, 40'h300, 1, 1, DATA, 4'd3, 40'h300);
    checkOutput("s6_code", 32'(error_code_o), 2);
    checkOutput("s6_outstanding", 32'(outstanding_o), 1);

    // Full table with same-cycle completion still overflows
    doReset();
    for (int i = 0; i < 4; i++) req(40'h500 + 40'(i * 64));
    applyStimulus(1, 1, 40'h600, 1, 1, DATA, 4'd3, 40'h500);
    checkOutput("s7_code", 32'(error_code_o), 1);
    checkOutput("s7_outstanding", 32'(outstanding_o), 3);
    checkOutput("s7_max_latency", max_latency_o, 4);

    // Overflow outranks unmatched, and the first code sticks
    doReset();
    for (int i = 0; i < 4; i++) req(40'h700 + 40'(i * 64));
    applyStimulus(1, 1, 40'h800, 1, 1, DATA, 4'd3, 40'h900);
    checkOutput("s8_priority_code", 32'(error_code_o), 1);
    cmd(DATA, 40'hA00);
    checkOutput("s8_sticky_code", 32'(error_code_o), 1);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
